// File: rtl/qdiv_seq_if.sv
// Request/response bundle for qdiv_seq: operands and start in, quotient and status out.
interface qdiv_seq_if #(
   parameter int N = 32
);
   logic         i_start;
   logic [N-1:0] i_dividend;
   logic [N-1:0] i_divisor;
   logic [N-1:0] o_quotient;
   logic         o_busy;
   logic         o_complete;
   logic         o_ovr;
   logic         o_div0;

   modport master (
      output i_start, i_dividend, i_divisor,
      input  o_quotient, o_busy, o_complete, o_ovr, o_div0
   );

   modport slave (
      input  i_start, i_dividend, i_divisor,
      output o_quotient, o_busy, o_complete, o_ovr, o_div0
   );
endinterface

// File: rtl/qdiv_seq.sv
// Restoring sign-magnitude (Q,N) divider, one quotient bit per clock; QDIV_SATURATE_EN saturates overflowed magnitudes.
// o_complete follows accept by N+Q-1 cycles (next cycle on divide-by-zero); i_start is ignored while o_busy.
module qdiv_seq #(
   parameter int Q = 15,
   parameter int N = 32
) (
   input  logic       i_clk,
   input  logic       i_rst,
   qdiv_seq_if.slave  bus
);
   localparam int W  = N - 1 + Q;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         r_state, w_state_nx;
   logic [CW-1:0]  r_cnt;
   logic [W-1:0]   r_dvd;
   logic [W-1:0]   r_quo;
   logic [N-2:0]   r_rem;
   logic [N-2:0]   r_div;
   logic           r_sign;
   logic [N-1:0]   r_quotient;
   logic           r_busy, r_complete, r_ovr, r_div0;

   logic           w_accept, w_div_zero, w_last, w_sign_in;
   logic [N-1:0]   w_rem_sh;
   logic           w_ge;
   logic [N-2:0]   w_rem_nx;
   logic [W-1:0]   w_quo_nx;
   logic           w_ovr;
   logic [N-2:0]   w_mag;

   assign w_accept   = bus.i_start && (r_state != CALC);
   assign w_div_zero = (bus.i_divisor[N-2:0] == '0);
   assign w_sign_in  = bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
   assign w_last     = (r_cnt == CW'(1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_nx = w_div_zero ? DONE : CALC;
         CALC: if (w_last)   w_state_nx = DONE;
         DONE: begin
            if (w_accept) w_state_nx = w_div_zero ? DONE : CALC;
            else          w_state_nx = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // Remainder stays below the divisor, so N-1 bits hold it and the difference.
   always_comb begin
      w_rem_sh = {r_rem, r_dvd[W-1]};
      w_ge     = (w_rem_sh >= {1'b0, r_div});
      w_rem_nx = w_ge ? (w_rem_sh[N-2:0] - r_div) : w_rem_sh[N-2:0];
      w_quo_nx = {r_quo[W-2:0], w_ge};
      w_ovr    = |w_quo_nx[W-1:N-1];
`ifdef QDIV_SATURATE_EN
      w_mag    = w_ovr ? '1 : w_quo_nx[N-2:0];
`else
      w_mag    = w_quo_nx[N-2:0];
`endif
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_dvd      <= '0;
         r_quo      <= '0;
         r_rem      <= '0;
         r_div      <= '0;
         r_sign     <= 1'b0;
         r_quotient <= '0;
         r_busy     <= 1'b0;
         r_complete <= 1'b0;
         r_ovr      <= 1'b0;
         r_div0     <= 1'b0;
      end else begin
         r_busy     <= (w_state_nx == CALC);
         r_complete <= (w_state_nx == DONE);
         if (w_accept) begin
            r_sign <= w_sign_in;
            r_dvd  <= {bus.i_dividend[N-2:0], {Q{1'b0}}};
            r_div  <= bus.i_divisor[N-2:0];
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= CW'(W);
            r_ovr  <= w_div_zero;
            r_div0 <= w_div_zero;
            if (w_div_zero) r_quotient <= {w_sign_in, {(N-1){1'b1}}};
         end else if (r_state == CALC) begin
            r_rem <= w_rem_nx;
            r_dvd <= {r_dvd[W-2:0], 1'b0};
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
               r_quotient <= {r_sign, w_mag};
               r_ovr      <= w_ovr;
            end
         end
      end
   end

   assign bus.o_quotient = r_quotient;
   assign bus.o_busy     = r_busy;
   assign bus.o_complete = r_complete;
   assign bus.o_ovr      = r_ovr;
   assign bus.o_div0     = r_div0;
endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: directed vectors, handshake corners and randomized operands vs an arithmetic model.
module tb_qdiv_seq;
   localparam int N   = 32;
   localparam int Q   = 15;
   localparam int LAT = N + Q - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qdiv_seq_if #(.N(N)) bus();
   qdiv_seq #(.Q(Q), .N(N)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   function automatic logic [N-1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                            output logic ovr, output logic d0);
      logic [63:0]  full;
      logic [N-2:0] mag;
      logic         sign;
      sign = a[N-1] ^ b[N-1];
      d0   = (b[N-2:0] == '0);
      if (d0) begin
         ovr = 1'b1;
         return {sign, {(N-1){1'b1}}};
      end
      full = ({33'd0, a[N-2:0]} << Q) / {33'd0, b[N-2:0]};
      ovr  = ((full >> (N-1)) != 64'd0);
      mag  = full[N-2:0];
`ifdef QDIV_SATURATE_EN
      if (ovr) mag = '1;
`endif
      return {sign, mag};
   endfunction

   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic ovr, output logic d0, output int lat);
      @(posedge clk); #1;
      bus.i_start = 1'b1; bus.i_dividend = a; bus.i_divisor = b;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      lat = 0;
      while (!bus.o_complete && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      q = bus.o_quotient; ovr = bus.o_ovr; d0 = bus.o_div0;
   endtask

   task automatic test_reset();
      bus.i_start = 1'b0; bus.i_dividend = '0; bus.i_divisor = '0;
      rst = 1'b1;
      #12;
      checks++; if (bus.o_quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %h expected 0", bus.o_quotient); end
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
      checks++; if (bus.o_complete !== 1'b0) begin errors++; $display("FAIL reset_complete: got %b expected 0", bus.o_complete); end
      checks++; if (bus.o_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", bus.o_ovr); end
      checks++; if (bus.o_div0 !== 1'b0) begin errors++; $display("FAIL reset_div0: got %b expected 0", bus.o_div0); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [N-1:0] va [6] = '{32'h0001_8000, 32'h8001_8000, 32'h8001_8000, 32'h0000_8000, 32'h0000_8000, 32'h4000_0000};
      logic [N-1:0] vb [6] = '{32'h0001_0000, 32'h0001_0000, 32'h8001_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001};
`ifdef QDIV_SATURATE_EN
      logic [N-1:0] vq [6] = '{32'h0000_C000, 32'h8000_C000, 32'h0000_C000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
`else
      logic [N-1:0] vq [6] = '{32'h0000_C000, 32'h8000_C000, 32'h0000_C000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
`endif
      logic vo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic vd [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [N-1:0] q;
      logic ovr, d0;
      int lat, exp_lat;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], q, ovr, d0, lat);
         exp_lat = vd[i] ? 0 : LAT;
         checks++; if (lat !== exp_lat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
         checks++; if (q !== vq[i]) begin errors++; $display("FAIL dir%0d_quotient: got %h expected %h", i, q, vq[i]); end
         checks++; if (ovr !== vo[i]) begin errors++; $display("FAIL dir%0d_ovr: got %b expected %b", i, ovr, vo[i]); end
         checks++; if (d0 !== vd[i]) begin errors++; $display("FAIL dir%0d_div0: got %b expected %b", i, d0, vd[i]); end
         @(posedge clk); #1;
         checks++; if (bus.o_complete !== 1'b0) begin errors++; $display("FAIL dir%0d_pulse: got %b expected 0", i, bus.o_complete); end
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      @(posedge clk); #1;
      bus.i_start = 1'b1; bus.i_dividend = 32'h0001_8000; bus.i_divisor = 32'h0001_0000;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      lat = 0;
      repeat (10) begin @(posedge clk); #1; lat++; end
      checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b expected 1", bus.o_busy); end
      bus.i_start = 1'b1; bus.i_dividend = 32'h7FFF_0000; bus.i_divisor = 32'h8000_0003;
      @(posedge clk); #1; lat++;
      bus.i_start = 1'b0;
      while (!bus.o_complete && lat < 200) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL ign_latency: got %0d expected %0d", lat, LAT); end
      checks++; if (bus.o_quotient !== 32'h0000_C000) begin errors++; $display("FAIL ign_quotient: got %h expected 0000c000", bus.o_quotient); end
      checks++; if (bus.o_ovr !== 1'b0) begin errors++; $display("FAIL ign_ovr: got %b expected 0", bus.o_ovr); end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(posedge clk); #1;
      bus.i_start = 1'b1; bus.i_dividend = 32'h0001_8000; bus.i_divisor = 32'h0001_0000;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      lat = 0;
      while (!bus.o_complete && lat < 200) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_lat1: got %0d expected %0d", lat, LAT); end
      checks++; if (bus.o_quotient !== 32'h0000_C000) begin errors++; $display("FAIL b2b_q1: got %h expected 0000c000", bus.o_quotient); end
      bus.i_start = 1'b1; bus.i_dividend = 32'h8003_0000; bus.i_divisor = 32'h0002_0000;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", bus.o_busy); end
      lat = 0;
      while (!bus.o_complete && lat < 200) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_lat2: got %0d expected %0d", lat, LAT); end
      checks++; if (bus.o_quotient !== 32'h8000_C000) begin errors++; $display("FAIL b2b_q2: got %h expected 8000c000", bus.o_quotient); end
   endtask

   task automatic test_reset_mid_calc();
      logic [N-1:0] q;
      logic ovr, d0, seen;
      int lat;
      @(posedge clk); #1;
      bus.i_start = 1'b1; bus.i_dividend = 32'h0003_0000; bus.i_divisor = 32'h0001_0000;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      checks++; if (bus.o_quotient !== '0) begin errors++; $display("FAIL rstmid_quotient: got %h expected 0", bus.o_quotient); end
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.o_busy); end
      checks++; if ({bus.o_complete, bus.o_ovr, bus.o_div0} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b expected 000", {bus.o_complete, bus.o_ovr, bus.o_div0}); end
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; seen |= bus.o_complete | bus.o_busy; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_aborted: got %b expected 0", seen); end
      run_op(32'h0000_8000, 32'h0002_0000, q, ovr, d0, lat);
      checks++; if (q !== 32'h0000_2000) begin errors++; $display("FAIL rstmid_after_q: got %h expected 00002000", q); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rstmid_after_lat: got %0d expected %0d", lat, LAT); end
   endtask

   task automatic test_random();
      logic [N-1:0] a, b, q, eq;
      logic ovr, d0, eovr, ed0;
      int lat, elat;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = {1'($urandom), 31'($urandom) >> $urandom_range(0, 30)};
            2: b = {1'($urandom), a[N-2:0] >> $urandom_range(0, 12)};
            default: b = {1'($urandom), 31'd0};
         endcase
         eq = ref_div(a, b, eovr, ed0);
         elat = ed0 ? 0 : LAT;
         run_op(a, b, q, ovr, d0, lat);
         checks++; if (q !== eq) begin errors++; $display("FAIL rnd%0d_quotient: %h/%h got %h expected %h", i, a, b, q, eq); end
         checks++; if (ovr !== eovr) begin errors++; $display("FAIL rnd%0d_ovr: got %b expected %b", i, ovr, eovr); end
         checks++; if (d0 !== ed0) begin errors++; $display("FAIL rnd%0d_div0: got %b expected %b", i, d0, ed0); end
         checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, elat); end
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_calc();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
